// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: accepts one byte per transmit handshake while idle and
// shifts it out LSB-first as start bit, 8 data bits, stop bit.
module uart_tx_8n1 #(
  parameter int BAUD_RATE    = 9600,
  parameter int SYS_CLK_FREQ = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       is_transmitting,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_reg;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_idx_reg;
  logic [CNT_W-1:0] baud_cnt_reg;
  logic             tx_reg;
  logic             busy_reg;
  logic             done_reg;

  assign tx              = tx_reg;
  assign is_transmitting = busy_reg;
  assign tx_done         = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      baud_cnt_reg <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          if (transmit) begin
            shift_reg    <= tx_byte;
            baud_cnt_reg <= BAUD_RELOAD;
            tx_reg       <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= START;
          end
        end

        START: begin
          if (baud_cnt_reg == '0) begin
            tx_reg       <= shift_reg[0];
            baud_cnt_reg <= BAUD_RELOAD;
            bit_idx_reg  <= '0;
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt_reg == '0) begin
            baud_cnt_reg <= BAUD_RELOAD;
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end else begin
              // Next bit to drive is the one that becomes shift_reg[0] after the shift.
              tx_reg      <= shift_reg[1];
              shift_reg   <= {1'b0, shift_reg[7:1]};
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt_reg == '0) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Directed bench for uart_tx_8n1: a 4-clock-per-bit instance for the protocol
// cases and a default-rate instance for the 1250-clock-per-bit frame.
module tb_uart_tx_8n1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       transmit = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       sel_def = 1'b0;

  logic tx_s, busy_s, done_s;
  logic tx_d, busy_d, done_d;
  logic trans_s, trans_d;

  int n_assert = 0;
  int n_fail   = 0;

  localparam int MAXLOG = 13000;
  logic tx_log   [0:MAXLOG-1];
  logic busy_log [0:MAXLOG-1];
  logic done_log [0:MAXLOG-1];

  assign trans_s = transmit & ~sel_def;
  assign trans_d = transmit & sel_def;

  always #5 clk = ~clk;

  uart_tx_8n1 #(.BAUD_RATE(10), .SYS_CLK_FREQ(40)) dut (
    .clk(clk), .rst(rst), .transmit(trans_s), .tx_byte(tx_byte),
    .tx(tx_s), .is_transmitting(busy_s), .tx_done(done_s)
  );

  uart_tx_8n1 dut_def (
    .clk(clk), .rst(rst), .transmit(trans_d), .tx_byte(tx_byte),
    .tx(tx_d), .is_transmitting(busy_d), .tx_done(done_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records ncyc cycles; c=0 is the cycle after the posedge that sampled transmit.
  task automatic capture(input int ncyc, input int off_c, input int pulse_c,
                         input logic [7:0] pulse_byte, input int chg_c,
                         input logic [7:0] chg_byte, input int rst_c);
    for (int c = 0; c < ncyc; c++) begin
      step();
      tx_log[c]   = sel_def ? tx_d   : tx_s;
      busy_log[c] = sel_def ? busy_d : busy_s;
      done_log[c] = sel_def ? done_d : done_s;
      if (c == off_c) transmit = 1'b0;
      if (c == pulse_c) begin transmit = 1'b1; tx_byte = pulse_byte; end
      if (c == pulse_c + 1) transmit = 1'b0;
      if (c == chg_c) tx_byte = chg_byte;
      if (c == rst_c) rst = 1'b1;
      if (c == rst_c + 1) rst = 1'b0;
    end
  endtask

  // Receiver model: samples mid-bit starting from a frame beginning at index s.
  function automatic logic [7:0] decode(input int s, input int cpb);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = tx_log[s + cpb/2 + cpb*(i+1)];
    return b;
  endfunction

  function automatic int count_busy(input int n);
    int k = 0;
    for (int i = 0; i < n; i++) if (busy_log[i] === 1'b1) k++;
    return k;
  endfunction

  function automatic int count_done(input int n);
    int k = 0;
    for (int i = 0; i < n; i++) if (done_log[i] === 1'b1) k++;
    return k;
  endfunction

  task automatic chk_frame(input string tag, input int s, input int cpb, input logic [7:0] exp);
    chk({tag, "_start"}, 32'(tx_log[s + cpb/2]), 32'd0);
    chk({tag, "_data"}, 32'(decode(s, cpb)), 32'(exp));
    chk({tag, "_stop"}, 32'(tx_log[s + cpb/2 + cpb*9]), 32'd1);
  endtask

  logic [9:0] exp_a5 = 10'b11_0100_1010;

  initial begin
    // Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tx", 32'(tx_s), 32'd1);
      chk("rst_busy", 32'(busy_s), 32'd0);
      chk("rst_done", 32'(done_s), 32'd0);
    end
    rst = 1'b0;
    step();
    chk("post_rst_tx", 32'(tx_s), 32'd1);
    chk("post_rst_busy", 32'(busy_s), 32'd0);

    // Reset and transmit together: nothing latched.
    rst = 1'b1; transmit = 1'b1; tx_byte = 8'h99;
    step();
    rst = 1'b0; transmit = 1'b0;
    chk("rst_win_busy", 32'(busy_s), 32'd0);
    step();
    chk("rst_win_idle_busy", 32'(busy_s), 32'd0);
    chk("rst_win_idle_tx", 32'(tx_s), 32'd1);

    // Single 0xA5 frame, traced cycle by cycle.
    tx_byte = 8'hA5; transmit = 1'b1;
    capture(45, 0, -10, 8'h00, -10, 8'h00, -10);
    for (int c = 0; c < 40; c++) chk($sformatf("a5_tx_c%0d", c), 32'(tx_log[c]), 32'(exp_a5[c/4]));
    chk("a5_busy_cnt", 32'(count_busy(45)), 32'd40);
    chk("a5_busy_last", 32'(busy_log[39]), 32'd1);
    chk("a5_busy_fall", 32'(busy_log[40]), 32'd0);
    chk("a5_done_cnt", 32'(count_done(45)), 32'd1);
    chk("a5_done_pos", 32'(done_log[40]), 32'd1);
    chk("a5_idle_tx", 32'(tx_log[44]), 32'd1);

    // Busy rejection: 0xFF request at cycle 10 is dropped.
    tx_byte = 8'h3C; transmit = 1'b1;
    capture(60, 0, 9, 8'hFF, -10, 8'h00, -10);
    chk_frame("busy_rej", 0, 4, 8'h3C);
    chk("busy_rej_busy_cnt", 32'(count_busy(60)), 32'd40);
    chk("busy_rej_done_cnt", 32'(count_done(60)), 32'd1);
    chk("busy_rej_no_second", 32'(busy_log[59]), 32'd0);
    chk("busy_rej_line_idle", 32'(tx_log[59]), 32'd1);

    // Back-to-back with transmit held: 0x00 then 0x81 after one idle cycle.
    tx_byte = 8'h00; transmit = 1'b1;
    capture(90, 41, -10, 8'h00, 20, 8'h81, -10);
    chk_frame("b2b_first", 0, 4, 8'h00);
    chk("b2b_gap_tx", 32'(tx_log[40]), 32'd1);
    chk("b2b_gap_busy", 32'(busy_log[40]), 32'd0);
    chk("b2b_second_start_tx", 32'(tx_log[41]), 32'd0);
    chk("b2b_second_busy", 32'(busy_log[41]), 32'd1);
    chk_frame("b2b_second", 41, 4, 8'h81);
    chk("b2b_busy_cnt", 32'(count_busy(90)), 32'd80);
    chk("b2b_done_cnt", 32'(count_done(90)), 32'd2);
    chk("b2b_done2_pos", 32'(done_log[81]), 32'd1);

    // Reset at cycle 17 of a 0x55 frame.
    tx_byte = 8'h55; transmit = 1'b1;
    capture(30, 0, -10, 8'h00, -10, 8'h00, 16);
    chk("abort_pre_tx", 32'(tx_log[16]), 32'd0);
    chk("abort_pre_busy", 32'(busy_log[16]), 32'd1);
    chk("abort_tx", 32'(tx_log[17]), 32'd1);
    chk("abort_busy", 32'(busy_log[17]), 32'd0);
    chk("abort_busy_cnt", 32'(count_busy(30)), 32'd17);
    chk("abort_no_done", 32'(count_done(30)), 32'd0);

    tx_byte = 8'h12; transmit = 1'b1;
    capture(45, 0, -10, 8'h00, -10, 8'h00, -10);
    chk_frame("after_abort", 0, 4, 8'h12);
    chk("after_abort_busy_cnt", 32'(count_busy(45)), 32'd40);
    chk("after_abort_done_cnt", 32'(count_done(45)), 32'd1);

    // Default rate instance: 1250 clocks per bit.
    sel_def = 1'b1;
    step();
    tx_byte = 8'h41; transmit = 1'b1;
    capture(12510, 0, -10, 8'h00, -10, 8'h00, -10);
    chk("def_start_first", 32'(tx_log[0]), 32'd0);
    chk("def_start_last", 32'(tx_log[1249]), 32'd0);
    chk("def_bit0_first", 32'(tx_log[1250]), 32'd1);
    chk_frame("def_frame", 0, 1250, 8'h41);
    chk("def_busy_cnt", 32'(count_busy(12510)), 32'd12500);
    chk("def_done_cnt", 32'(count_done(12510)), 32'd1);
    chk("def_done_pos", 32'(done_log[12500]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
